// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding
// and the coin denomination table.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_e;

  localparam int COIN_SEL_W = 2;
  localparam int COIN_VAL_W = 4;

  // Index 0 is the smallest coin: {1, 2, 5, 10}.
  localparam logic [3:0][COIN_VAL_W-1:0] COIN_TBL = {4'd10, 4'd5, 4'd2, 4'd1};

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_SEL_W-1:0] sel);
    return COIN_TBL[sel];
  endfunction

endpackage

// File: rtl/vend_timeout.sv
// Idle timer for the CREDIT state: synchronous clear, counts while enabled and
// flags the terminal cycle so the controller can refund on that same edge.
module vend_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/vend_ctrl_param.sv
// Coin-operated vending controller: accumulates credit, dispenses products
// priced by the PRICES table, returns change, and refunds on cancel or idle timeout.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 6,
  parameter int N_PROD      = 4,
  parameter logic [N_PROD-1:0][CREDIT_W-1:0] PRICES =
    {CREDIT_W'(3), CREDIT_W'(12), CREDIT_W'(5), CREDIT_W'(7)},
  parameter int TIMEOUT_CYC = 1000,
  localparam int PSEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coin_valid,
  input  logic [COIN_SEL_W-1:0] coin_sel,
  input  logic                  buy,
  input  logic [PSEL_W-1:0]     prod_sel,
  input  logic                  cancel,
  output logic [CREDIT_W-1:0]   credit,
  output logic                  coin_reject,
  output logic                  insufficient,
  output logic                  dispense,
  output logic [PSEL_W-1:0]     product,
  output logic                  change_valid,
  output logic [CREDIT_W-1:0]   change_amt,
  output logic                  busy
);

  vend_state_e         state, state_nxt;
  logic [CREDIT_W-1:0] remainder, rem_nxt, credit_nxt;
  logic [PSEL_W-1:0]   prod_nxt;
  logic                coin_reject_nxt, insufficient_nxt;
  logic                coin_acc, tmo_clr, tc;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic                pvalid;

  // Extra top bit carries the overflow; callers reject the coin instead of wrapping.
  function automatic logic [CREDIT_W:0] add_coin(input logic [CREDIT_W-1:0] c,
                                                 input logic [COIN_SEL_W-1:0] s);
    return {1'b0, c} + (CREDIT_W+1)'(coin_value(s));
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [PSEL_W-1:0] sel);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel == PSEL_W'(i)) p = PRICES[i];
    end
    return p;
  endfunction

  function automatic logic prod_in_range(input logic [PSEL_W-1:0] sel);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel == PSEL_W'(i)) ok = 1'b1;
    end
    return ok;
  endfunction

  assign tmo_clr = coin_acc || (state != ST_CREDIT);

  vend_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmo_clr),
    .en   (state == ST_CREDIT),
    .tc   (tc)
  );

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    rem_nxt          = remainder;
    prod_nxt         = product;
    coin_reject_nxt  = 1'b0;
    insufficient_nxt = 1'b0;
    coin_acc         = 1'b0;
    sum              = add_coin(credit, coin_sel);
    price            = price_of(prod_sel);
    pvalid           = prod_in_range(prod_sel);

    case (state)
      ST_IDLE, ST_CREDIT: begin
        // cancel beats buy beats coin; a coin arriving alongside either is returned
        if (cancel) begin
          coin_reject_nxt = coin_valid;
          if (state == ST_CREDIT) begin
            state_nxt  = ST_CHANGE;
            rem_nxt    = credit;
            credit_nxt = '0;
          end
        end else if (buy) begin
          coin_reject_nxt = coin_valid;
          if (pvalid && (credit >= price)) begin
            state_nxt = ST_DISPENSE;
            rem_nxt   = credit - price;
            prod_nxt  = prod_sel;
          end else begin
            insufficient_nxt = 1'b1;
          end
        end else if (coin_valid) begin
          if (sum[CREDIT_W]) begin
            coin_reject_nxt = 1'b1;
          end else begin
            coin_acc   = 1'b1;
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = ST_CREDIT;
          end
        end else if (tc) begin
          state_nxt  = ST_CHANGE;
          rem_nxt    = credit;
          credit_nxt = '0;
        end
      end
      ST_DISPENSE: begin
        coin_reject_nxt = coin_valid;
        credit_nxt      = '0;
        state_nxt       = (remainder != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_nxt = coin_valid;
        credit_nxt      = '0;
        rem_nxt         = '0;
        state_nxt       = ST_IDLE;
      end
      default: begin
        state_nxt  = ST_IDLE;
        credit_nxt = '0;
        rem_nxt    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pulse comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      remainder    <= '0;
      product      <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      remainder    <= rem_nxt;
      product      <= prod_nxt;
      coin_reject  <= coin_reject_nxt;
      insufficient <= insufficient_nxt;
      dispense     <= (state_nxt == ST_DISPENSE);
      change_valid <= (state_nxt == ST_CHANGE);
      change_amt   <= (state_nxt == ST_CHANGE) ? rem_nxt : '0;
      busy         <= (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param with default parameters
// (prices {7,5,12,3}, 6-bit credit, 1000-cycle timeout).
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       buy;
  logic [1:0] prod_sel;
  logic       cancel;
  logic [5:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       dispense;
  logic [1:0] product;
  logic       change_valid;
  logic [5:0] change_amt;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int wait_n;

  vend_ctrl_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_valid  (coin_valid),
    .coin_sel    (coin_sel),
    .buy         (buy),
    .prod_sel    (prod_sel),
    .cancel      (cancel),
    .credit      (credit),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
    .dispense    (dispense),
    .product     (product),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // coin_sel: 0->1, 1->2, 2->5, 3->10
  task automatic step(input logic cv, input logic [1:0] cs, input logic b,
                      input logic [1:0] ps, input logic cn);
    coin_valid = cv;
    coin_sel   = cs;
    buy        = b;
    prod_sel   = ps;
    cancel     = cn;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    buy        = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    coin_valid = 1'b0; coin_sel = 2'd0; buy = 1'b0; prod_sel = 2'd0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_change_amt", change_amt, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // coins 5 + 2, buy product 0 (price 7): exact payment, no change
    step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    chk("c5_credit", credit, 5);
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    chk("c52_credit", credit, 7);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    chk("p0_dispense", dispense, 1);
    chk("p0_product", product, 0);
    chk("p0_busy", busy, 1);
    chk("p0_no_change", change_valid, 0);
    idle();
    chk("p0_after_dispense", dispense, 0);
    chk("p0_after_change", change_valid, 0);
    chk("p0_after_credit", credit, 0);
    chk("p0_after_busy", busy, 0);

    // coin 10, buy product 3 (price 3): change 7; coin during DISPENSE is rejected
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    chk("c10_credit", credit, 10);
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    chk("p3_dispense", dispense, 1);
    chk("p3_product", product, 3);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("p3_change_valid", change_valid, 1);
    chk("p3_change_amt", change_amt, 7);
    chk("p3_dispense_off", dispense, 0);
    chk("p3_busy_coin_reject", coin_reject, 1);
    chk("p3_credit_cleared", credit, 0);
    idle();
    chk("p3_idle_change_valid", change_valid, 0);
    chk("p3_idle_change_amt", change_amt, 0);
    chk("p3_idle_busy", busy, 0);
    chk("p3_product_held", product, 3);

    // credit 60, coin 10 overflows and is rejected; buy product 2 (12) -> change 48
    repeat (6) step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    chk("c60_credit", credit, 60);
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    chk("ovf_coin_reject", coin_reject, 1);
    chk("ovf_credit", credit, 60);
    idle();
    chk("ovf_reject_one_cycle", coin_reject, 0);
    step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
    chk("p2_dispense", dispense, 1);
    chk("p2_product", product, 2);
    idle();
    chk("p2_change_valid", change_valid, 1);
    chk("p2_change_amt", change_amt, 48);
    idle();

    // fill to exactly 63 (accepted), then a further 1 is rejected; cancel refunds 63
    repeat (6) step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("max_credit", credit, 63);
    chk("max_no_reject", coin_reject, 0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("max_plus1_reject", coin_reject, 1);
    chk("max_plus1_credit", credit, 63);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("max_cancel_change_valid", change_valid, 1);
    chk("max_cancel_change_amt", change_amt, 63);
    idle();

    // coin 2, buy product 1 (price 5) refused; cancel refunds 2
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    chk("p1_insufficient", insufficient, 1);
    chk("p1_no_dispense", dispense, 0);
    chk("p1_credit_kept", credit, 2);
    chk("p1_not_busy", busy, 0);
    idle();
    chk("p1_insufficient_one_cycle", insufficient, 0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("cancel_change_valid", change_valid, 1);
    chk("cancel_change_amt", change_amt, 2);
    chk("cancel_credit", credit, 0);
    idle();

    // cancel while IDLE does nothing
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("idle_cancel_change_valid", change_valid, 0);
    chk("idle_cancel_busy", busy, 0);

    // timeout: coin 1 then silence; refund lands 1000 cycles after the coin
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("tmo_credit", credit, 1);
    wait_n = 0;
    while (!change_valid && wait_n < 1100) begin
      idle();
      wait_n++;
    end
    chk("tmo_cycles", wait_n, 1000);
    chk("tmo_change_amt", change_amt, 1);
    idle();
    chk("tmo_after_busy", busy, 0);
    chk("tmo_after_credit", credit, 0);

    // a second coin restarts the timer
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    repeat (500) idle();
    chk("tmo2_no_early_refund", change_valid, 0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    chk("tmo2_credit", credit, 2);
    wait_n = 0;
    while (!change_valid && wait_n < 1100) begin
      idle();
      wait_n++;
    end
    chk("tmo2_cycles", wait_n, 1000);
    chk("tmo2_change_amt", change_amt, 2);
    idle();

    // coin together with buy at credit 7 on product 0: dispense and reject the coin
    step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 2'd0, 1'b0);
    chk("buycoin_dispense", dispense, 1);
    chk("buycoin_reject", coin_reject, 1);
    chk("buycoin_product", product, 0);
    idle();
    chk("buycoin_credit", credit, 0);
    chk("buycoin_no_change", change_valid, 0);

    // reset during DISPENSE: the pending change never appears
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    chk("rstd_dispense", dispense, 1);
    rst_n = 1'b0;
    #1;
    chk("rstd_dispense_async", dispense, 0);
    chk("rstd_product_async", product, 0);
    chk("rstd_credit_async", credit, 0);
    chk("rstd_busy_async", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rstd_no_change_1", change_valid, 0);
    idle();
    chk("rstd_no_change_2", change_valid, 0);
    chk("rstd_busy", busy, 0);

    // reset during CHANGE: pulse cut immediately, credit 0 after release
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    idle();
    chk("rstc_change_valid", change_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rstc_change_valid_async", change_valid, 0);
    chk("rstc_change_amt_async", change_amt, 0);
    chk("rstc_credit_async", credit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("rstc_no_change", change_valid, 0);
    chk("rstc_credit", credit, 0);

    // first edge after release already accepts a coin
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
    chk("post_rst_coin", credit, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 Parameter CREDIT_W, default 6: width of credit, price and change values.
REQ-002 Parameter N_PROD, default 4: number of selectable products; PSEL_W = clog2(N_PROD).
REQ-003 Parameter PRICES, default {7,5,12,3}: per-product price, index 0 first, each < 2^CREDIT_W.
REQ-004 Parameter TIMEOUT_CYC, default 1000: idle cycles in CREDIT before automatic refund.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 coin_valid  in  1  one-cycle strobe; a coin is present.
REQ-008 coin_sel  in  2  coin denomination index, values 1,2,5,10.
REQ-009 buy  in  1  one-cycle purchase request.
REQ-010 prod_sel  in  PSEL_W  product selected, sampled with buy.
REQ-011 cancel  in  1  one-cycle refund request.
REQ-012 credit  out  CREDIT_W  current accumulated credit.
REQ-013 coin_reject  out  1  one-cycle pulse; coin returned, credit unchanged.
REQ-014 insufficient  out  1  one-cycle pulse; buy refused.
REQ-015 dispense  out  1  one-cycle pulse; product released.
REQ-016 product  out  PSEL_W  product index; valid while dispense=1, holds last value otherwise.
REQ-017 change_valid  out  1  one-cycle pulse; change_amt is valid.
REQ-018 change_amt  out  CREDIT_W  amount returned; 0 when change_valid=0.
REQ-019 busy  out  1  high in DISPENSE and CHANGE.

Function
REQ-020 FSM states: IDLE, CREDIT, DISPENSE, CHANGE.
REQ-021 IDLE: coin accepted -> CREDIT with credit = coin value, visible the next cycle.
REQ-022 CREDIT: each accepted coin adds its value; one-cycle latency strobe-to-credit.
REQ-023 Coin causing credit + value > 2^CREDIT_W-1: coin_reject, credit unchanged; no wrap-around.
REQ-024 Priority in one cycle: cancel > buy > coin; a coin with buy or cancel is rejected (coin_reject=1).
REQ-025 buy with credit >= PRICES[prod_sel] -> DISPENSE; remainder = credit - price latched.
REQ-026 buy with credit < price, or prod_sel >= N_PROD: insufficient pulse, state and credit unchanged.
REQ-027 DISPENSE lasts exactly 1 cycle: dispense=1, product=latched index; next CHANGE if remainder>0, else IDLE with credit=0.
REQ-028 CHANGE lasts exactly 1 cycle: change_valid=1, change_amt=remainder; credit cleared; next IDLE.
REQ-029 cancel in CREDIT -> CHANGE with remainder = credit; cancel in IDLE ignored (no pulse).
REQ-030 Timeout counter clears on entry to CREDIT and on every accepted coin; reaching TIMEOUT_CYC -> CHANGE, refunding full credit.
REQ-031 In DISPENSE and CHANGE: coins rejected, buy and cancel ignored, no insufficient pulse.
REQ-032 At most one of dispense, change_valid high per cycle; outputs registered.

Reset
REQ-033 rst_n low forces IDLE, credit=0, remainder=0, product=0, timeout counter=0, all pulses 0, immediately and independent of clk.
REQ-034 Reset mid-DISPENSE or mid-CHANGE discards the pending pulse; no change is emitted after release.
REQ-035 First state change occurs on the first rising clk edge after rst_n deasserts.

Structure
REQ-036 Package vend_pkg holds the state enum, the coin value table {1,2,5,10} and the coin_sel width constant.
REQ-037 One sub-module vend_timeout (load-clear counter, terminal-count pulse, TIMEOUT_CYC parameter) instantiated once.
REQ-038 PRICES is the only product-dependent data; no per-product logic is hand-coded.

Verification
REQ-039 Coins 5,2 then buy prod 0 (price 7) -> credit 7, dispense=1 product=0, no change_valid, credit 0.
REQ-040 Coin 10, buy prod 3 (price 3) -> dispense product=3, next cycle change_valid change_amt=7, then IDLE.
REQ-041 Credit 60, coin 10 -> coin_reject, credit stays 60; buy prod 2 -> dispense, change_amt=48.
REQ-042 Coin 2, buy prod 1 (price 5) -> insufficient, credit 2; then cancel -> change_amt=2.
REQ-043 Coin 1, no activity for TIMEOUT_CYC cycles -> change_valid change_amt=1 at the counter's terminal cycle.
REQ-044 coin and buy in the same cycle with credit 7 on prod 0 -> dispense and coin_reject; rst_n low during CHANGE -> no change_valid, credit 0.
